// File: rtl/sram_arbiter_rr.sv
// ---------------------------------------------------------------------------
// sram_arbiter_rr
//
// Shares one SRAM controller port among NUM_PORTS CPU cores. Each core
// presents a read/write request with address and write data; one core at a
// time owns the memory port. Ownership is re-evaluated on every clock edge
// where the SRAM controller is not busy. While the controller is busy the
// grant is locked so a transfer in flight is never torn away from its core.
//
// Arbitration is round-robin by default; setting FIXED_PRIO makes the lowest
// requesting index win. A write always takes precedence over a read from the
// same core. Per-port saturating counters record completed accesses.
// ---------------------------------------------------------------------------
module sram_arbiter_rr #(
    parameter int NUM_PORTS  = 2,
    parameter int ADDR_W     = 17,
    parameter int DATA_W     = 32,
    parameter int CNT_W      = 16,
    parameter int FIXED_PRIO = 0
) (
    input  logic                          clk,
    input  logic                          reset_n,
    input  logic [NUM_PORTS-1:0]          port_rd,
    input  logic [NUM_PORTS-1:0]          port_wr,
    input  logic [NUM_PORTS*ADDR_W-1:0]   port_addr,
    input  logic [NUM_PORTS*DATA_W-1:0]   port_wd,
    output logic [NUM_PORTS-1:0]          port_stall,
    input  logic                          mem_busy,
    output logic                          mem_we,
    output logic                          mem_re,
    output logic [ADDR_W-1:0]             mem_addr,
    output logic [DATA_W-1:0]             mem_wd,
    output logic [$clog2(NUM_PORTS)-1:0]  owner,
    output logic                          gnt_valid,
    output logic [NUM_PORTS*CNT_W-1:0]    gnt_count
);

    // Width of a port index, and one extra bit so that base + offset can be
    // formed without overflow before the modulo fold.
    localparam int OWN_W  = $clog2(NUM_PORTS);
    localparam int CAND_W = OWN_W + 1;

    localparam logic [CAND_W-1:0] NUM_PORTS_C = CAND_W'(NUM_PORTS);
    localparam logic [OWN_W-1:0]  LAST_PORT   = OWN_W'(NUM_PORTS - 1);

    // Arbiter view of the grant registers combined with the controller status.
    localparam logic [1:0] ST_IDLE   = 2'd0;  // no grant held
    localparam logic [1:0] ST_ACCESS = 2'd1;  // grant held, transfer completes this cycle
    localparam logic [1:0] ST_HOLD   = 2'd2;  // grant held, controller stalled

    logic [NUM_PORTS-1:0] req;
    logic                 any_req;
    logic [1:0]           state;
    logic [OWN_W-1:0]     rr_ptr;
    logic [OWN_W-1:0]     arb_base;
    logic [OWN_W-1:0]     winner;
    logic [OWN_W-1:0]     rr_next;
    logic [CNT_W-1:0]     cnt_q [NUM_PORTS];

    // A core wants the memory if it asks for either a read or a write.
    always_comb begin
        req     = port_rd | port_wr;
        any_req = |req;
    end

    // Decode the arbiter state from the grant flag and the controller stall.
    always_comb begin
        if (!gnt_valid) begin
            state = ST_IDLE;
        end else if (mem_busy) begin
            state = ST_HOLD;
        end else begin
            state = ST_ACCESS;
        end
    end

    // Pick the next owner: first requester at or after the search base, wrapping.
    always_comb begin : winner_search
        logic [CAND_W-1:0] cand;
        // NOTE: every variable written in a combinational block gets a
        // default before any conditional assignment, otherwise a latch is
        // inferred to hold the old value on paths that skip the assignment.
        winner   = '0;
        cand     = '0;
        arb_base = (FIXED_PRIO != 0) ? '0 : rr_ptr;
        // Scanning from the far end means the last hit written is the first
        // requester in search order, so no "found" flag is needed.
        for (int k = NUM_PORTS - 1; k >= 0; k--) begin
            cand = {1'b0, arb_base} + CAND_W'(k);
            if (cand >= NUM_PORTS_C) begin
                cand = cand - NUM_PORTS_C;
            end
            if (req[cand[OWN_W-1:0]]) begin
                winner = cand[OWN_W-1:0];
            end
        end
        rr_next = (winner == LAST_PORT) ? '0 : winner + OWN_W'(1);
    end

    // Grant registers: re-arbitrate whenever the controller is not busy.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            gnt_valid <= 1'b0;
            owner     <= '0;
            rr_ptr    <= '0;
        end else if (state != ST_HOLD) begin
            // NOTE: sequential state uses non-blocking assignments so every
            // register samples the values from before this edge, regardless
            // of statement order or which block is evaluated first.
            if (any_req) begin
                gnt_valid <= 1'b1;
                owner     <= winner;
                if (FIXED_PRIO == 0) begin
                    rr_ptr <= rr_next;
                end
            end else begin
                gnt_valid <= 1'b0;
            end
        end
    end

    // Completed-access counters: bump the owner's count on each finished cycle.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            // NOTE: the counter array is a handful of registers that software
            // reads after reset, so it is cleared like any other state rather
            // than treated as uninitialised storage.
            for (int i = 0; i < NUM_PORTS; i++) begin
                cnt_q[i] <= '0;
            end
        end else if ((state == ST_ACCESS) && req[owner] && (cnt_q[owner] != '1)) begin
            cnt_q[owner] <= cnt_q[owner] + CNT_W'(1);
        end
    end

    // Flatten the counter array onto the output bus, port i at slice i.
    generate
        for (genvar g = 0; g < NUM_PORTS; g++) begin : g_cnt_flat
            assign gnt_count[g*CNT_W +: CNT_W] = cnt_q[g];
        end
    endgenerate

    // Steer the owner's address and data to the controller; write beats read.
    always_comb begin
        mem_addr = port_addr[owner*ADDR_W +: ADDR_W];
        mem_wd   = port_wd[owner*DATA_W +: DATA_W];
        mem_we   = gnt_valid & port_wr[owner];
        mem_re   = gnt_valid & port_rd[owner] & ~port_wr[owner];
    end

    // Stall every requester except the owner whose transfer completes this cycle.
    always_comb begin
        port_stall = '0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            port_stall[i] = req[i] & ~((state == ST_ACCESS) && (owner == OWN_W'(i)));
        end
    end

endmodule

// File: doc/sram_arbiter_rr.md
Name: sram_arbiter_rr

Overview:
- Parametrised N-port arbiter that shares one SRAM controller port among NUM_PORTS CPU cores.
- Successor to the fixed two-core "using"-bit arbiter.
- Adds generic port count, selectable round-robin or fixed-priority mode, grant locking while the SRAM is busy, write-over-read precedence, per-port grant counters and asynchronous reset.
- Sits between the cpu cores' memory-stage request signals and the SRAM controller.

Parameters:
NUM_PORTS, 2, number of requesting cores (2..8)
ADDR_W, 17, word address width
DATA_W, 32, data width
CNT_W, 16, width of each per-port saturating grant counter
FIXED_PRIO, 0, 0 = round-robin, 1 = fixed priority (lowest index wins)

Ports:
clk  input  1  system clock, rising edge
reset_n  input  1  asynchronous active-low reset
port_rd  input  NUM_PORTS  per-port read request
port_wr  input  NUM_PORTS  per-port write request
port_addr  input  NUM_PORTS*ADDR_W  flattened per-port address, port i at [i*ADDR_W +: ADDR_W]
port_wd  input  NUM_PORTS*DATA_W  flattened per-port write data
port_stall  output  NUM_PORTS  per-port stall to core
mem_busy  input  1  SRAM controller stall/status
mem_we  output  1  write enable to SRAM controller
mem_re  output  1  read enable to SRAM controller
mem_addr  output  ADDR_W  selected address
mem_wd  output  DATA_W  selected write data
owner  output  $clog2(NUM_PORTS)  current grant index
gnt_valid  output  1  a grant is held
gnt_count  output  NUM_PORTS*CNT_W  per-port completed-access counters

Behaviour:
- Clock and reset: one clock, clk. Reset is reset_n, asynchronous and active-low.
- Reset values: gnt_valid=0, owner=0, rr_ptr=0, all gnt_count=0. port_stall = req, since nothing is granted. mem_we=mem_re=0. mem_addr/mem_wd = port 0 values.
- Request: req[i] = port_rd[i] | port_wr[i].
- States, derived from registers and mem_busy:
  - IDLE: gnt_valid=0.
  - ACCESS: gnt_valid=1 and mem_busy=0.
  - HOLD: gnt_valid=1 and mem_busy=1.
- Re-arbitration occurs at every posedge where mem_busy=0, in IDLE or ACCESS:
  - If any req: gnt_valid<=1 and owner<=winner.
  - If no req: gnt_valid<=0, giving IDLE.
- HOLD (mem_busy=1): owner, gnt_valid and rr_ptr are frozen. No arbitration, even if other ports request or the owner drops its request.
- Round-robin winner: first i with req[i]=1, searching from rr_ptr upward modulo NUM_PORTS. On grant, rr_ptr<=(winner+1) mod NUM_PORTS.
- Fixed-priority winner: lowest i with req[i]=1. rr_ptr is ignored.
- Memory-side outputs (combinational from owner):
  - mem_addr/mem_wd always carry the owner's values.
  - mem_we = gnt_valid & port_wr[owner].
  - mem_re = gnt_valid & port_rd[owner] & ~port_wr[owner]; write has precedence.
- Stall: port_stall[i] = req[i] & ~(gnt_valid & owner==i & ~mem_busy). A non-requesting port never stalls.
- Latency: a port requesting into IDLE stalls exactly 1 cycle, then is granted.
- Two RR ports requesting continuously with mem_busy=0 alternate grants every cycle.
- Owner deasserting req in ACCESS: mem_we/mem_re fall that cycle. Re-arbitration happens at the next edge.
- Counters: gnt_count[owner] increments at each posedge where gnt_valid & req[owner] & ~mem_busy. Each counter saturates at all-ones and never wraps.
- Reset mid-HOLD: grant dropped immediately and asynchronously. mem_we/mem_re go 0 without waiting for mem_busy.

Test Plan:
- Reset: assert reset_n=0 with port_wr=2'b11 -> gnt_valid=0, mem_we=0, port_stall=2'b11, all counters 0. Release with no requests -> stays IDLE.
- NUM_PORTS=2 RR, port 0 read only at addr 0x00010, mem_busy=0 -> cycle 0 stall[0]=1; cycle 1 owner=0, mem_re=1, mem_addr=0x00010, stall[0]=0; gnt_count[0]=1 after that edge.
- NUM_PORTS=4 RR, all ports request for 8 cycles, mem_busy=0 -> owner sequence 0,1,2,3,0,1,2,3; each gnt_count=2.
- HOLD: port 1 granted write, mem_busy=1 for 3 cycles while port 2 requests -> owner stays 1, mem_we=1, stall[1]=stall[2]=1. After mem_busy falls, port 1 completes; owner=2 on the following edge.
- FIXED_PRIO=1, ports 0 and 3 request continuously -> owner=0 every cycle, stall[3]=1 throughout.
- Port 2 asserts rd and wr together -> mem_we=1, mem_re=0. CNT_W=2 with 5 completed accesses -> counter reads 3.
